// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control in, instruction memory port, IF/ID bundle out.
// The fetch stage takes the master side; the environment takes the slave side.
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        misalign;

    modport master (
        input  stall,
        input  redirect,
        input  redirect_pc,
        input  imem_data,
        output imem_addr,
        output if_valid,
        output if_instr,
        output if_pc,
        output if_pc_plus4,
        output misalign
    );

    modport slave (
        output stall,
        output redirect,
        output redirect_pc,
        output imem_data,
        input  imem_addr,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        input  if_pc_plus4,
        input  misalign
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem, fills the IF/ID register.
// A misaligned redirect parks the stage in a fault state until reset.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input logic           clk,
    input logic           reset,
    fetch_stage_if.master bus
);

    typedef enum logic {
        S_RUN,
        S_FAULT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc4_q, ipc4_d;
    logic [31:0] pc_inc;

    assign pc_inc = pc_q + PC_STEP;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            ipc_q   <= 32'd0;
            ipc4_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ipc4_d  = ipc4_q;
        unique case (1'b1)
            (state_q == S_FAULT): begin
            end
            (state_q == S_RUN) && bus.redirect: begin
                pc_d    = bus.redirect_pc;
                valid_d = 1'b0;
                instr_d = 32'd0;
                ipc_d   = 32'd0;
                ipc4_d  = 32'd0;
                // keep the bad target in pc so it is visible
                if (bus.redirect_pc[1:0] != 2'b00) begin
                    state_d = S_FAULT;
                end
            end
            (state_q == S_RUN) && !bus.redirect && bus.stall: begin
            end
            default: begin
                pc_d    = pc_inc;
                valid_d = 1'b1;
                instr_d = bus.imem_data;
                ipc_d   = pc_q;
                ipc4_d  = pc_inc;
            end
        endcase
    end

    assign bus.imem_addr   = pc_q;
    assign bus.if_valid    = valid_q;
    assign bus.if_instr    = instr_q;
    assign bus.if_pc       = ipc_q;
    assign bus.if_pc_plus4 = ipc4_q;
    assign bus.misalign    = (state_q == S_FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an expected-state scoreboard.
// Two instances: RESET_PC=0 for the main flow, RESET_PC=FFFFFFFC for wrap.
module tb_fetch_stage;

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
        logic        chk_pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_stage_if bus_a ();
    fetch_stage_if bus_b ();

    fetch_stage #(.RESET_PC(32'd0)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    function automatic logic [31:0] mem_word(logic [31:0] a);
        case (a)
            32'd0:   return 32'h2000_0003;
            32'd4:   return 32'h2021_0004;
            default: return 32'h8C00_0000 | a;
        endcase
    endfunction

    assign bus_a.imem_data = mem_word(bus_a.imem_addr);
    assign bus_b.imem_data = mem_word(bus_b.imem_addr);

    function automatic exp_t mk(string t,
                                logic [31:0] addr,
                                logic [31:0] instr,
                                logic [31:0] pc,
                                logic [31:0] pc4,
                                logic valid,
                                logic mis,
                                logic chk_pc);
        exp_t e;
        e.tag    = t;
        e.addr   = addr;
        e.instr  = instr;
        e.pc     = pc;
        e.pc4    = pc4;
        e.valid  = valid;
        e.mis    = mis;
        e.chk_pc = chk_pc;
        return e;
    endfunction

    task automatic cmp(string t, string f,
                       logic [31:0] o, logic [31:0] e);
        total++;
        assert (o === e)
        else begin
            bad++;
            $error("FAIL %s.%s got=%h want=%h", t, f, o, e);
        end
    endtask

    task automatic check(bit b);
        exp_t        e;
        logic [31:0] addr, instr, pc, pc4;
        logic        valid, mis;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard empty got=0 want=1");
            return;
        end
        e     = sb.pop_front();
        addr  = b ? bus_b.imem_addr   : bus_a.imem_addr;
        instr = b ? bus_b.if_instr    : bus_a.if_instr;
        pc    = b ? bus_b.if_pc       : bus_a.if_pc;
        pc4   = b ? bus_b.if_pc_plus4 : bus_a.if_pc_plus4;
        valid = b ? bus_b.if_valid    : bus_a.if_valid;
        mis   = b ? bus_b.misalign    : bus_a.misalign;
        cmp(e.tag, "addr", addr, e.addr);
        cmp(e.tag, "instr", instr, e.instr);
        cmp(e.tag, "valid", {31'd0, valid}, {31'd0, e.valid});
        cmp(e.tag, "mis", {31'd0, mis}, {31'd0, e.mis});
        if (e.chk_pc) begin
            cmp(e.tag, "pc", pc, e.pc);
            cmp(e.tag, "pc4", pc4, e.pc4);
        end
    endtask

    // drive one cycle of inputs, record expectation, clock, compare
    task automatic step(bit b, logic rst, logic st, logic rd,
                        logic [31:0] rpc, exp_t e);
        if (b) begin
            rst_b             = rst;
            bus_b.stall       = st;
            bus_b.redirect    = rd;
            bus_b.redirect_pc = rpc;
        end else begin
            rst_a             = rst;
            bus_a.stall       = st;
            bus_a.redirect    = rd;
            bus_a.redirect_pc = rpc;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        check(b);
    endtask

    initial begin
        rst_a             = 1'b1;
        rst_b             = 1'b1;
        bus_a.stall       = 1'b0;
        bus_a.redirect    = 1'b0;
        bus_a.redirect_pc = 32'd0;
        bus_b.stall       = 1'b0;
        bus_b.redirect    = 1'b0;
        bus_b.redirect_pc = 32'd0;
        #1;

        step(0, 1, 0, 0, 0, mk("rst", 0, 0, 0, 0, 0, 0, 1));
        step(0, 0, 0, 0, 0,
             mk("f0", 4, 32'h2000_0003, 0, 4, 1, 0, 1));
        step(0, 0, 0, 0, 0,
             mk("f1", 8, 32'h2021_0004, 4, 8, 1, 0, 1));
        step(0, 0, 0, 0, 0,
             mk("f2", 12, 32'h8C00_0008, 8, 12, 1, 0, 1));

        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0,
                 mk("stall", 12, 32'h8C00_0008, 8, 12, 1, 0, 1));
        end
        step(0, 0, 0, 0, 0,
             mk("unstall", 16, 32'h8C00_000C, 12, 16, 1, 0, 1));
        step(0, 0, 0, 0, 0,
             mk("f4", 20, 32'h8C00_0010, 16, 20, 1, 0, 1));
        step(0, 0, 0, 0, 0,
             mk("f5", 24, 32'h8C00_0014, 20, 24, 1, 0, 1));
        step(0, 0, 0, 0, 0,
             mk("f6", 28, 32'h8C00_0018, 24, 28, 1, 0, 1));

        step(0, 0, 1, 1, 32'd8,
             mk("redir", 8, 0, 0, 0, 0, 0, 1));
        step(0, 0, 0, 0, 0,
             mk("after_redir", 12, 32'h8C00_0008, 8, 12, 1, 0, 1));

        step(0, 0, 0, 1, 32'h0000_000A,
             mk("misal", 32'hA, 0, 0, 0, 0, 1, 0));
        step(0, 0, 0, 1, 32'd0,
             mk("mis_redir", 32'hA, 0, 0, 0, 0, 1, 0));
        step(0, 0, 1, 0, 0,
             mk("mis_stall", 32'hA, 0, 0, 0, 0, 1, 0));
        step(0, 0, 0, 0, 0,
             mk("mis_hold", 32'hA, 0, 0, 0, 0, 1, 0));
        step(0, 1, 0, 0, 0,
             mk("mis_rst", 0, 0, 0, 0, 0, 0, 1));
        step(0, 0, 0, 0, 0,
             mk("post_rst", 4, 32'h2000_0003, 0, 4, 1, 0, 1));
        step(0, 0, 0, 0, 0,
             mk("post_rst2", 8, 32'h2021_0004, 4, 8, 1, 0, 1));

        step(0, 1, 1, 1, 32'd16,
             mk("rst_redir", 0, 0, 0, 0, 0, 0, 1));
        step(0, 1, 0, 1, 32'h0000_0003,
             mk("rst_misal", 0, 0, 0, 0, 0, 0, 1));
        step(0, 0, 0, 0, 0,
             mk("rst_resume", 4, 32'h2000_0003, 0, 4, 1, 0, 1));

        step(1, 1, 0, 0, 0,
             mk("b_rst", 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 1));
        step(1, 0, 0, 0, 0,
             mk("wrap", 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 1, 0, 1));
        step(1, 0, 0, 0, 0,
             mk("wrap2", 4, 32'h2000_0003, 0, 4, 1, 0, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory.
- Owns the program counter and drives the memory's word address.
- Captures the returned 32-bit MIPS instruction into an IF/ID pipeline register for the decoder.
- Supports stall (hold) and branch redirect (flush plus new PC); flags misaligned redirect targets and stops fetching on them.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- PC_STEP, 32'd4, byte increment per sequential fetch. Must be 4.

Ports:
- clk  input  1  rising-edge clock, single domain.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID register this cycle.
- redirect  input  1  branch taken; load redirect_pc and flush.
- redirect_pc  input  32  byte address of branch target.
- imem_addr  output  32  byte address to instruction memory (combinational copy of PC).
- imem_data  input  32  instruction word returned combinationally by instruction memory.
- if_valid  output  1  IF/ID register holds a real instruction.
- if_instr  output  32  registered instruction.
- if_pc  output  32  address the registered instruction was fetched from.
- if_pc_plus4  output  32  if_pc + 4, for branch-target computation downstream.
- misalign  output  1  sticky fault: a redirect target had bits [1:0] != 0.

Behaviour:
- Internal pc register; imem_addr = pc at all times, with no register between them.
- Reset (sampled at posedge only): pc <= RESET_PC; if_valid, if_instr, if_pc, if_pc_plus4, misalign <= 0. Reset overrides every other input.
- Per-edge priority (highest first): reset > misalign held > redirect > stall > normal fetch.
- Normal fetch (no stall, no redirect, misalign=0):
  - pc <= pc + 4;
  - if_instr <= imem_data;
  - if_pc <= pc;
  - if_pc_plus4 <= pc + 4;
  - if_valid <= 1.
- Latency: the instruction at address A appears on if_instr one edge after imem_addr == A.
- Stall (no redirect): pc and all IF/ID outputs hold their values, including if_valid.
- Redirect with redirect_pc[1:0] == 0:
  - pc <= redirect_pc;
  - if_valid <= 0 and if_instr <= 0 (bubble); if_pc and if_pc_plus4 <= 0.
  - Redirect wins over a simultaneous stall.
- Redirect with redirect_pc[1:0] != 0:
  - misalign <= 1; pc <= redirect_pc (address is visible for debug);
  - if_valid <= 0, if_instr <= 0.
- While misalign == 1: pc and IF/ID outputs hold, if_valid stays 0, and further redirects and stalls are ignored. Only reset clears it.
- Arithmetic: pc + 4 is a 32-bit unsigned add that wraps modulo 2^32. 32'hFFFFFFFC + 4 = 32'h00000000, with no fault.
- A misaligned sequential PC is impossible, since RESET_PC and accepted redirect targets are word-aligned.
- Reset asserted mid-stall or mid-redirect: the next state is the reset state, regardless of other inputs.
- No combinational path from stall, redirect or redirect_pc to any output. imem_addr depends only on pc.

Test Plan:
- Reset then free-run, with memory word at 0 = 32'h20000003 and at 4 = 32'h20210004:
  - cycle 1 after reset release: imem_addr=0, if_valid=0;
  - next edge: if_instr=32'h20000003, if_pc=0, if_pc_plus4=4, if_valid=1, imem_addr=4;
  - next edge: if_instr=32'h20210004, if_pc=4.
- Stall for 3 cycles while pc=12: imem_addr stays 12 and if_instr/if_pc stay unchanged for 3 edges. On release, if_pc=12 on the following edge.
- Redirect: at pc=28 assert redirect with redirect_pc=8 together with stall=1.
  - Next edge: pc=8, if_valid=0, if_instr=0.
  - Following edge: if_pc=8, if_valid=1.
- Misaligned redirect: redirect_pc=32'h0000000A.
  - Next edge: misalign=1, imem_addr=32'h0000000A, if_valid=0.
  - A later redirect to 0 is ignored.
  - A reset pulse restores pc=0 and misalign=0.
- Wrap: RESET_PC=32'hFFFFFFFC.
  - After one fetch: if_pc=32'hFFFFFFFC, if_pc_plus4=0, imem_addr=0.
  - misalign stays 0.
- Reset mid-operation: assert reset during a redirect cycle. Next edge: pc=RESET_PC and all IF/ID outputs 0.
